modulo_dispensador_rolhas: RTL and testbench



---
 rtl/modulo_dispensador_rolhas_pkg.sv | 33 +++
 rtl/modulo_temporizador_vedacao.sv | 39 +++
 rtl/modulo_dispensador_rolhas.sv | 220 ++++++++++++++++++++++
 tb/tb_modulo_dispensador_rolhas.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_dispensador_rolhas_pkg.sv
// -----------------------------------------------------------------------------
// pkg_rolhas
// Shared definitions for the cork-handling blocks: state encodings of the
// sealing and refill controllers, default stock thresholds and the stock
// value type used by the cork register and the display encoders.
// -----------------------------------------------------------------------------
package pkg_rolhas;

   localparam int LARGURA_ESTOQUE      = 7;
   localparam int MIN_ROLHAS_PADRAO    = 5;
   localparam int LOTE_PADRAO          = 20;
   localparam int MAX_ROLHAS_PADRAO    = 99;
   localparam int TEMPO_VEDACAO_PADRAO = 3;
   localparam int TIMEOUT_REP_PADRAO   = 15;

   typedef logic [LARGURA_ESTOQUE-1:0] estoque_t;

   typedef enum logic [2:0] {
      OCIOSO    = 3'd0,
      ALIMENTA  = 3'd1,
      VEDANDO   = 3'd2,
      CONCLUI   = 3'd3,
      BLOQUEADO = 3'd4
   } estado_vedacao_t;

   typedef enum logic [1:0] {
      REP_OCIOSO   = 2'd0,
      REP_PEDE     = 2'd1,
      REP_ADICIONA = 2'd2,
      REP_ESPERA   = 2'd3
   } estado_rep_t;

endpackage

// File: rtl/modulo_temporizador_vedacao.sv
// -----------------------------------------------------------------------------
// modulo_temporizador_vedacao
// Loadable down-counter with a terminal flag. Used as the piston timer and as
// the refill watchdog.
//   clk, clr : clock, synchronous active-high clear
//   carga    : load 'valor' (has priority over counting)
//   conta    : decrement by one while nonzero
//   valor    : load value
//   fim      : counter is at zero
// -----------------------------------------------------------------------------
module modulo_temporizador_vedacao #(
   parameter int LARGURA = 4
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               carga,
   input  logic               conta,
   input  logic [LARGURA-1:0] valor,
   output logic               fim
);

   logic [LARGURA-1:0] contagem_r;

   // down-counter register: load wins, saturates at zero
   always_ff @(posedge clk) begin
      if (clr) begin
         contagem_r <= '0;
      end else if (carga) begin
         contagem_r <= valor;
      end else if (conta && (contagem_r != '0)) begin
         contagem_r <= contagem_r - LARGURA'(1);
      end else begin
         contagem_r <= contagem_r;
      end
   end

   assign fim = (contagem_r == '0);

endmodule

// File: rtl/modulo_dispensador_rolhas.sv
// -----------------------------------------------------------------------------
// modulo_dispensador_rolhas
// Cork consumer: serves sealing requests (one cork per bottle, timed piston,
// 4-phase-style ack), watches stock and runs a refill handshake with the
// supplier. Emits mutually exclusive dec_rolha / add_lote strobes toward the
// cork register; add_lote wins and dec_rolha is deferred one cycle.
//   clk, clr        : clock, synchronous active-high reset
//   enable          : allows new sealing requests to be accepted
//   pedido_vedacao  : sealing request (level)   ack_vedacao : sealing done
//   estoque         : current stock             piston      : actuator on
//   dec_rolha       : subtract-one strobe       add_lote    : add-lot strobe
//   falta_rolha     : registered estoque < MIN_ROLHAS
//   rep_req/rep_ack : refill handshake with the supplier
// Optional macro REPOSICAO_TIMEOUT_EN adds erro_reposicao and a watchdog on
// the refill request.
// -----------------------------------------------------------------------------
module modulo_dispensador_rolhas
   import pkg_rolhas::*;
#(
   parameter int LARGURA        = LARGURA_ESTOQUE,
   parameter int MIN_ROLHAS     = MIN_ROLHAS_PADRAO,
   parameter int LOTE_REPOSICAO = LOTE_PADRAO,
   parameter int MAX_ROLHAS     = MAX_ROLHAS_PADRAO,
   parameter int TEMPO_VEDACAO  = TEMPO_VEDACAO_PADRAO,
   parameter int TIMEOUT_REP    = TIMEOUT_REP_PADRAO
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               enable,
   input  logic               pedido_vedacao,
   input  logic [LARGURA-1:0] estoque,
   output logic               ack_vedacao,
   output logic               piston,
   output logic               dec_rolha,
   output logic               add_lote,
   output logic               falta_rolha,
   output logic               rep_req,
   input  logic               rep_ack
`ifdef REPOSICAO_TIMEOUT_EN
   ,
   output logic               erro_reposicao
`endif
);

   // one timer width fits both the piston time and the watchdog limit
   localparam int VALOR_MAX = (TEMPO_VEDACAO > TIMEOUT_REP) ? TEMPO_VEDACAO : TIMEOUT_REP;
   localparam int LARGURA_T = $clog2(VALOR_MAX + 1);

   estado_vedacao_t sel_r, sel_next;
   estado_rep_t     rep_r, rep_next;

   logic           tmr_carga_s;
   logic           tmr_conta_s;
   logic           tmr_fim_s;
   logic [LARGURA:0] soma_s;
   logic           cabe_lote_s;

   // stock + lot evaluated one bit wider so it can never wrap
   assign soma_s      = {1'b0, estoque} + (LARGURA+1)'(LOTE_REPOSICAO);
   assign cabe_lote_s = (soma_s <= (LARGURA+1)'(MAX_ROLHAS));
   assign tmr_conta_s = (sel_r == VEDANDO);

   modulo_temporizador_vedacao #(.LARGURA(LARGURA_T)) u_tmr_piston (
      .clk   (clk),
      .clr   (clr),
      .carga (tmr_carga_s),
      .conta (tmr_conta_s),
      .valor (LARGURA_T'(TEMPO_VEDACAO - 1)),
      .fim   (tmr_fim_s)
   );

`ifdef REPOSICAO_TIMEOUT_EN
   logic wd_carga_s;
   logic wd_fim_s;
   logic erro_set_s;
   logic erro_r;

   modulo_temporizador_vedacao #(.LARGURA(LARGURA_T)) u_tmr_watchdog (
      .clk   (clk),
      .clr   (clr),
      .carga (wd_carga_s),
      .conta (rep_r == REP_PEDE),
      .valor (LARGURA_T'(TIMEOUT_REP - 1)),
      .fim   (wd_fim_s)
   );

   // sticky refill error, cleared only by clr
   always_ff @(posedge clk) begin
      if (clr) begin
         erro_r <= 1'b0;
      end else begin
         erro_r <= erro_r | erro_set_s;
      end
   end

   assign erro_reposicao = erro_r;
`endif

   // sealing next-state logic; leaving ALIMENTA requires the dec strobe to have fired
   always_comb begin
      sel_next    = sel_r;
      tmr_carga_s = 1'b0;
      case (sel_r)
         OCIOSO: begin
            if (enable && pedido_vedacao) begin
               if (estoque != '0) begin
                  sel_next = ALIMENTA;
               end else begin
                  sel_next = BLOQUEADO;
               end
            end else begin
               sel_next = OCIOSO;
            end
         end
         ALIMENTA: begin
            if (dec_rolha) begin
               sel_next    = VEDANDO;
               tmr_carga_s = 1'b1;
            end else begin
               sel_next = ALIMENTA;
            end
         end
         VEDANDO: begin
            if (tmr_fim_s) begin
               sel_next = CONCLUI;
            end else begin
               sel_next = VEDANDO;
            end
         end
         CONCLUI: begin
            if (!pedido_vedacao) begin
               sel_next = OCIOSO;
            end else begin
               sel_next = CONCLUI;
            end
         end
         BLOQUEADO: begin
            if (estoque != '0) begin
               sel_next = ALIMENTA;
            end else begin
               sel_next = BLOQUEADO;
            end
         end
         default: sel_next = OCIOSO;
      endcase
   end

   // refill next-state logic
   always_comb begin
      rep_next = rep_r;
`ifdef REPOSICAO_TIMEOUT_EN
      wd_carga_s = 1'b0;
      erro_set_s = 1'b0;
`endif
      case (rep_r)
         REP_OCIOSO: begin
`ifdef REPOSICAO_TIMEOUT_EN
            if (falta_rolha && cabe_lote_s && !erro_r) begin
               rep_next   = REP_PEDE;
               wd_carga_s = 1'b1;
            end else begin
               rep_next = REP_OCIOSO;
            end
`else
            if (falta_rolha && cabe_lote_s) begin
               rep_next = REP_PEDE;
            end else begin
               rep_next = REP_OCIOSO;
            end
`endif
         end
         REP_PEDE: begin
            if (rep_ack) begin
               rep_next = REP_ADICIONA;
`ifdef REPOSICAO_TIMEOUT_EN
            end else if (wd_fim_s) begin
               rep_next   = REP_OCIOSO;
               erro_set_s = 1'b1;
`endif
            end else begin
               rep_next = REP_PEDE;
            end
         end
         REP_ADICIONA: rep_next = REP_ESPERA;
         REP_ESPERA: begin
            if (!rep_ack) begin
               rep_next = REP_OCIOSO;
            end else begin
               rep_next = REP_ESPERA;
            end
         end
         default: rep_next = REP_OCIOSO;
      endcase
   end

   // state and output registers; outputs decode the next state so they align with it
   always_ff @(posedge clk) begin
      if (clr) begin
         sel_r       <= OCIOSO;
         rep_r       <= REP_OCIOSO;
         ack_vedacao <= 1'b0;
         piston      <= 1'b0;
         dec_rolha   <= 1'b0;
         add_lote    <= 1'b0;
         falta_rolha <= 1'b0;
         rep_req     <= 1'b0;
      end else begin
         sel_r       <= sel_next;
         rep_r       <= rep_next;
         ack_vedacao <= (sel_next == CONCLUI);
         piston      <= (sel_next == VEDANDO);
         // add_lote owns the register port; a colliding decrement waits a cycle
         dec_rolha   <= (sel_next == ALIMENTA) && (rep_next != REP_ADICIONA);
         add_lote    <= (rep_next == REP_ADICIONA);
         falta_rolha <= (estoque < LARGURA'(MIN_ROLHAS));
         rep_req     <= (rep_next == REP_PEDE);
      end
   end

endmodule

// File: tb/tb_modulo_dispensador_rolhas.sv
module tb_modulo_dispensador_rolhas;

   logic       clk = 1'b0;
   logic       clr;
   logic       enable;
   logic       pedido_vedacao;
   logic [6:0] estoque;
   logic       rep_ack;
   logic       ack_vedacao, piston, dec_rolha, add_lote, falta_rolha, rep_req;
`ifdef REPOSICAO_TIMEOUT_EN
   logic       erro_reposicao;
   logic       erro_b;
`endif

   logic [6:0] estoque_b;
   logic       ack_b, piston_b, dec_b, add_b, falta_b, req_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   modulo_dispensador_rolhas dut (
      .clk            (clk),
      .clr            (clr),
      .enable         (enable),
      .pedido_vedacao (pedido_vedacao),
      .estoque        (estoque),
      .ack_vedacao    (ack_vedacao),
      .piston         (piston),
      .dec_rolha      (dec_rolha),
      .add_lote       (add_lote),
      .falta_rolha    (falta_rolha),
      .rep_req        (rep_req),
      .rep_ack        (rep_ack)
`ifdef REPOSICAO_TIMEOUT_EN
      ,
      .erro_reposicao (erro_reposicao)
`endif
   );

   modulo_dispensador_rolhas #(.MIN_ROLHAS(90)) dut_min90 (
      .clk            (clk),
      .clr            (clr),
      .enable         (1'b0),
      .pedido_vedacao (1'b0),
      .estoque        (estoque_b),
      .ack_vedacao    (ack_b),
      .piston         (piston_b),
      .dec_rolha      (dec_b),
      .add_lote       (add_b),
      .falta_rolha    (falta_b),
      .rep_req        (req_b),
      .rep_ack        (1'b0)
`ifdef REPOSICAO_TIMEOUT_EN
      ,
      .erro_reposicao (erro_b)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      tick();
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      enable = 1'b1; pedido_vedacao = 1'b1; estoque = 7'd30; rep_ack = 1'b0;
      estoque_b = 7'd85;
      clr = 1'b1;
      tick();
      tick();
      total++;
      if ({ack_vedacao, piston, dec_rolha, add_lote, falta_rolha, rep_req} !== 6'b000000) begin
         $display("FAIL reset_outputs got=%b want=000000",
                  {ack_vedacao, piston, dec_rolha, add_lote, falta_rolha, rep_req});
         bad++;
      end
      pedido_vedacao = 1'b0;
      clr = 1'b0;
   endtask

   // request with stock 30: dec at 1, piston 2..4, ack at 5
   task automatic test_sealing();
      do_reset();
      estoque = 7'd30; enable = 1'b1; pedido_vedacao = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         total++;
         if (dec_rolha !== (k == 1) || piston !== (k >= 2 && k <= 4) ||
             ack_vedacao !== (k >= 5) || add_lote !== 1'b0) begin
            $display("FAIL seal_seq k=%0d got dec/pis/ack/add=%b%b%b%b want=%b%b%b0",
                     k, dec_rolha, piston, ack_vedacao, add_lote,
                     (k == 1), (k >= 2 && k <= 4), (k >= 5));
            bad++;
         end
      end
      pedido_vedacao = 1'b0;
      tick();
      total++;
      if (ack_vedacao !== 1'b0) begin
         $display("FAIL seal_ack_drop got=%b want=0", ack_vedacao);
         bad++;
      end
   endtask

   // empty stock: blocked with no decrement until stock appears
   task automatic test_blocked();
      do_reset();
      estoque = 7'd0; enable = 1'b1; pedido_vedacao = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         total++;
         if (dec_rolha !== 1'b0 || piston !== 1'b0 || ack_vedacao !== 1'b0) begin
            $display("FAIL blocked_idle k=%0d got dec/pis/ack=%b%b%b want=000",
                     k, dec_rolha, piston, ack_vedacao);
            bad++;
         end
      end
      estoque = 7'd20;
      for (int k = 1; k <= 5; k++) begin
         tick();
         total++;
         if (dec_rolha !== (k == 1) || piston !== (k >= 2 && k <= 4) || ack_vedacao !== (k == 5)) begin
            $display("FAIL blocked_resume k=%0d got dec/pis/ack=%b%b%b want=%b%b%b",
                     k, dec_rolha, piston, ack_vedacao, (k == 1), (k >= 2 && k <= 4), (k == 5));
            bad++;
         end
      end
      pedido_vedacao = 1'b0;
      tick();
   endtask

   // low stock: request, one add_lote, no new request until ack releases
   task automatic test_refill();
      int adds;
      do_reset();
      estoque = 7'd4; pedido_vedacao = 1'b0;
      tick();
      total++;
      if (falta_rolha !== 1'b1 || rep_req !== 1'b0) begin
         $display("FAIL refill_falta got falta/req=%b%b want=10", falta_rolha, rep_req);
         bad++;
      end
      tick();
      total++;
      if (rep_req !== 1'b1) begin
         $display("FAIL refill_req got=%b want=1", rep_req);
         bad++;
      end
      rep_ack = 1'b1;
      adds = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (add_lote === 1'b1) adds++;
         total++;
         if (rep_req !== 1'b0 || add_lote !== (k == 1)) begin
            $display("FAIL refill_ack k=%0d got req/add=%b%b want=0%b", k, rep_req, add_lote, (k == 1));
            bad++;
         end
      end
      total++;
      if (adds !== 1) begin
         $display("FAIL refill_add_count got=%0d want=1", adds);
         bad++;
      end
      rep_ack = 1'b0;
      tick();
      total++;
      if (rep_req !== 1'b0) begin
         $display("FAIL refill_release got=%b want=0", rep_req);
         bad++;
      end
      tick();
      total++;
      if (rep_req !== 1'b1) begin
         $display("FAIL refill_rearm got=%b want=1", rep_req);
         bad++;
      end
      do_reset();
   endtask

   // MIN_ROLHAS=90: refill only when stock+20 <= 99
   task automatic test_ceiling();
      logic [6:0] vals [3];
      logic       want [3];
      vals[0] = 7'd85; want[0] = 1'b0;
      vals[1] = 7'd80; want[1] = 1'b0;
      vals[2] = 7'd79; want[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         do_reset();
         estoque_b = vals[i];
         tick();
         tick();
         tick();
         total++;
         if (falta_b !== 1'b1 || req_b !== want[i]) begin
            $display("FAIL ceiling est=%0d got falta/req=%b%b want=1%b", vals[i], falta_b, req_b, want[i]);
            bad++;
         end
      end
   endtask

   // add_lote and ALIMENTA collide: add first, dec one cycle later
   task automatic test_conflict();
      do_reset();
      estoque = 7'd4; pedido_vedacao = 1'b0; enable = 1'b1;
      tick();
      tick();
      rep_ack = 1'b1; pedido_vedacao = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         total++;
         if (add_lote !== (k == 1) || dec_rolha !== (k == 2) || piston !== (k >= 3 && k <= 5) ||
             ack_vedacao !== (k == 6)) begin
            $display("FAIL conflict k=%0d got add/dec/pis/ack=%b%b%b%b want=%b%b%b%b",
                     k, add_lote, dec_rolha, piston, ack_vedacao,
                     (k == 1), (k == 2), (k >= 3 && k <= 5), (k == 6));
            bad++;
         end
      end
      rep_ack = 1'b0; pedido_vedacao = 1'b0;
      do_reset();
   endtask

   // enable gates only the start; early request drop still completes the bottle
   task automatic test_enable_drop();
      do_reset();
      estoque = 7'd50; enable = 1'b0; pedido_vedacao = 1'b1;
      tick();
      tick();
      total++;
      if (dec_rolha !== 1'b0) begin
         $display("FAIL enable_gate got=%b want=0", dec_rolha);
         bad++;
      end
      enable = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) begin
            enable = 1'b0; pedido_vedacao = 1'b0;
         end
         total++;
         if (dec_rolha !== (k == 1) || piston !== (k >= 2 && k <= 4) || ack_vedacao !== (k == 5)) begin
            $display("FAIL enable_drop k=%0d got dec/pis/ack=%b%b%b want=%b%b%b",
                     k, dec_rolha, piston, ack_vedacao, (k == 1), (k >= 2 && k <= 4), (k == 5));
            bad++;
         end
      end
   endtask

`ifdef REPOSICAO_TIMEOUT_EN
   // stuck supplier: 15 cycles of request, then sticky error and no retry
   task automatic test_timeout();
      do_reset();
      estoque = 7'd4; rep_ack = 1'b0; pedido_vedacao = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         total++;
         if (rep_req !== (k >= 2 && k <= 16) || erro_reposicao !== (k >= 17)) begin
            $display("FAIL timeout k=%0d got req/err=%b%b want=%b%b",
                     k, rep_req, erro_reposicao, (k >= 2 && k <= 16), (k >= 17));
            bad++;
         end
      end
      do_reset();
      total++;
      if (erro_reposicao !== 1'b0) begin
         $display("FAIL timeout_clr got=%b want=0", erro_reposicao);
         bad++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_sealing();
      test_blocked();
      test_refill();
      test_ceiling();
      test_conflict();
      test_enable_drop();
`ifdef REPOSICAO_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
